// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK transmit framer.
// BPSK_TX_CRC8_EN adds the CRCB state and the CRC-8 helper.
package bpsk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SYNCW,
        ST_PAYLOAD,
        ST_DONE
`ifdef BPSK_TX_CRC8_EN
        , ST_CRCB
`endif
    } tx_state_e;

    typedef struct packed {
        logic       first;
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hD3;
    localparam logic [7:0] CRC8_POLY         = 8'h07;

`ifdef BPSK_TX_CRC8_EN
    // Folds one byte into a running CRC-8, MSB first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            c = {c[6:0], 1'b0} ^ (((c[7] ^ data[i]) == 1'b1) ? CRC8_POLY : 8'h00);
        end
        return c;
    endfunction
`endif

endpackage

// File: rtl/bpsk_tx_framer_if.sv
// Byte source interface into the framer: byte, push, frame delimiters, and stop back-pressure.
// The source must not push while stop is high; pushes made anyway are dropped.
interface bpsk_tx_framer_if;
    logic [7:0] Byte;
    logic       pushByte;
    logic       Sync;
    logic       lastByte;
    logic       stop;

    modport master (output Byte, output pushByte, output Sync, output lastByte, input stop);
    modport slave  (input Byte, input pushByte, input Sync, input lastByte, output stop);
endinterface

// File: rtl/tx_byte_fifo.sv
// Synchronous FIFO of framed bytes with head peek; write visible at head one cycle later.
// Writes while full and reads while empty are ignored; full/empty derive from the registered count.
module tx_byte_fifo
    import bpsk_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en_i,
    input  fifo_entry_t wr_dat_i,
    input  logic        rd_en_i,
    output fifo_entry_t head_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int AW = $clog2(DEPTH);

    fifo_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          wr_ok;
    logic          rd_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign wr_ok   = wr_en_i && !full_o;
    assign rd_ok   = rd_en_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end

endmodule

// File: rtl/bpsk_tx_framer.sv
// Frames buffered bytes as preamble, sync word, payload (plus CRC-8 when BPSK_TX_CRC8_EN), SPB clocks per bit.
// First bit two clocks after the Sync push; stop mirrors FIFO full and excess pushes pulse overflow.
module bpsk_tx_framer
    import bpsk_pkg::*;
#(
    parameter int         DEPTH         = 16,
    parameter int         SPB           = 8,
    parameter int         PREAMBLE_BITS = 32,
    parameter logic [7:0] SYNC_WORD     = DEFAULT_SYNC_WORD
) (
    input  logic            clk,
    input  logic            reset,
    bpsk_tx_framer_if.slave src,
    output logic            bit_out,
    output logic            bit_strobe,
    output logic            tx_active,
    output logic            frame_done,
    output logic            overflow,
    output logic            underrun
);
    localparam int SW = $clog2(SPB);
    localparam int CW = ($clog2(PREAMBLE_BITS) > 3) ? $clog2(PREAMBLE_BITS) : 3;

    fifo_entry_t wr_entry;
    fifo_entry_t head;
    logic        full;
    logic        empty;
    logic        pop;

    tx_state_e   state_q;
    logic [SW-1:0] spb_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]  shreg_q;
    logic        last_q;
    logic        bit_out_q;
    logic        strobe_q;
    logic        tx_active_q;
    logic        frame_done_q;
    logic        overflow_q;
    logic        underrun_q;
`ifdef BPSK_TX_CRC8_EN
    logic [7:0]  crc_q;
`endif

    logic        period_end;
    logic        byte_end;

    assign wr_entry = '{first: src.Sync, last: src.lastByte, data: src.Byte};

    tx_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en_i  (src.pushByte),
        .wr_dat_i (wr_entry),
        .rd_en_i  (pop),
        .head_o   (head),
        .full_o   (full),
        .empty_o  (empty)
    );

    assign period_end = (spb_q == SW'(SPB - 1));
    assign byte_end   = period_end && (cnt_q == CW'(7));

    // The head of a frame stays queued until the sync word is done, so orphans are only dropped in IDLE.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            ST_IDLE:    pop = !empty && !head.first;
            ST_SYNCW:   pop = byte_end;
            ST_PAYLOAD: pop = byte_end && !last_q && !empty && !head.first;
            default:    pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            spb_q        <= '0;
            cnt_q        <= '0;
            shreg_q      <= '0;
            last_q       <= 1'b0;
            bit_out_q    <= 1'b0;
            strobe_q     <= 1'b0;
            tx_active_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef BPSK_TX_CRC8_EN
            crc_q        <= '0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            strobe_q     <= 1'b0;
            overflow_q   <= src.pushByte && full;
            case (state_q)
                ST_IDLE: begin
                    if (!empty && head.first) begin
                        state_q     <= ST_PREAMBLE;
                        spb_q       <= '0;
                        cnt_q       <= '0;
                        bit_out_q   <= 1'b1;
                        strobe_q    <= 1'b1;
                        tx_active_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    if (!period_end) begin
                        spb_q <= spb_q + SW'(1);
                    end else begin
                        // Defaults for the next bit period; the branches below override them.
                        spb_q     <= '0;
                        strobe_q  <= 1'b1;
                        cnt_q     <= cnt_q + CW'(1);
                        shreg_q   <= {shreg_q[6:0], 1'b0};
                        bit_out_q <= shreg_q[6];
                        case (state_q)
                            ST_PREAMBLE: begin
                                bit_out_q <= ~bit_out_q;
                                if (cnt_q == CW'(PREAMBLE_BITS - 1)) begin
                                    state_q   <= ST_SYNCW;
                                    cnt_q     <= '0;
                                    shreg_q   <= SYNC_WORD;
                                    bit_out_q <= SYNC_WORD[7];
`ifdef BPSK_TX_CRC8_EN
                                    crc_q     <= '0;
`endif
                                end
                            end
                            ST_SYNCW, ST_PAYLOAD: begin
                                if (cnt_q == CW'(7)) begin
                                    if (state_q == ST_PAYLOAD && last_q) begin
`ifdef BPSK_TX_CRC8_EN
                                        state_q   <= ST_CRCB;
                                        cnt_q     <= '0;
                                        shreg_q   <= crc_q;
                                        bit_out_q <= crc_q[7];
`else
                                        state_q      <= ST_DONE;
                                        frame_done_q <= 1'b1;
                                        tx_active_q  <= 1'b0;
                                        bit_out_q    <= 1'b0;
                                        strobe_q     <= 1'b0;
`endif
                                    end else if (state_q == ST_PAYLOAD && empty) begin
                                        state_q     <= ST_IDLE;
                                        underrun_q  <= 1'b1;
                                        tx_active_q <= 1'b0;
                                        bit_out_q   <= 1'b0;
                                        strobe_q    <= 1'b0;
                                    end else if (state_q == ST_PAYLOAD && head.first) begin
                                        state_q      <= ST_DONE;
                                        frame_done_q <= 1'b1;
                                        tx_active_q  <= 1'b0;
                                        bit_out_q    <= 1'b0;
                                        strobe_q     <= 1'b0;
                                    end else begin
                                        state_q   <= ST_PAYLOAD;
                                        cnt_q     <= '0;
                                        shreg_q   <= head.data;
                                        last_q    <= head.last;
                                        bit_out_q <= head.data[7];
`ifdef BPSK_TX_CRC8_EN
                                        crc_q     <= crc8_byte(crc_q, head.data);
`endif
                                    end
                                end
                            end
`ifdef BPSK_TX_CRC8_EN
                            ST_CRCB: begin
                                if (cnt_q == CW'(7)) begin
                                    state_q      <= ST_DONE;
                                    frame_done_q <= 1'b1;
                                    tx_active_q  <= 1'b0;
                                    bit_out_q    <= 1'b0;
                                    strobe_q     <= 1'b0;
                                end
                            end
`endif
                            default: begin
                                state_q <= ST_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign src.stop   = full;
    assign bit_out    = bit_out_q;
    assign bit_strobe = strobe_q;
    assign tx_active  = tx_active_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_bpsk_tx_framer.sv
// Randomised frame traffic against a queue-level model of the framing rules, plus directed corner cases.
// Build with +define+BPSK_TX_CRC8_EN to cover the CRC byte as well.
module tb_bpsk_tx_framer;
    import bpsk_pkg::*;

    localparam int         DEPTH = 16;
    localparam int         SPB   = 8;
    localparam int         PB    = 32;
    localparam logic [7:0] SYNCW = 8'hD3;

    logic clk = 1'b0;
    logic reset;
    logic bit_out, bit_strobe, tx_active, frame_done, overflow, underrun;

    always #5 clk = ~clk;

    bpsk_tx_framer_if src_if ();

    bpsk_tx_framer #(
        .DEPTH         (DEPTH),
        .SPB           (SPB),
        .PREAMBLE_BITS (PB),
        .SYNC_WORD     (SYNCW)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .src        (src_if),
        .bit_out    (bit_out),
        .bit_strobe (bit_strobe),
        .tx_active  (tx_active),
        .frame_done (frame_done),
        .overflow   (overflow),
        .underrun   (underrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: only ever appends/increments; scenarios work on deltas from a snapshot.
    bit   cap_bits[$];
    int   starts[$];
    int   act_cyc = 0, fd_cnt = 0, ur_cnt = 0, ov_cnt = 0, viol = 0;
    logic prev_bit = 1'b0, prev_act = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bit_strobe) cap_bits.push_back(bit_out);
            if (tx_active && !prev_act) starts.push_back(cyc);
            if (tx_active) act_cyc++;
            if (frame_done) fd_cnt++;
            if (underrun) ur_cnt++;
            if (overflow) ov_cnt++;
            if (!tx_active && bit_out) viol++;
            if (tx_active && !bit_strobe && (bit_out != prev_bit)) viol++;
        end
        prev_bit = bit_out;
        prev_act = tx_active;
    end

    fifo_entry_t scen[$];
    bit          exp_bits[$];
    int          efd, eur;
    int          s_bits, s_starts, s_act, s_fd, s_ur, s_ov, s_viol;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // Reference: walk the accepted entries as a queue and emit the whole bit stream of each frame.
    task automatic build_expect(input int n);
        fifo_entry_t q[$];
        fifo_entry_t cur;
        logic [7:0]  crc;
        logic [7:0]  sw;
        sw = SYNCW;
        exp_bits.delete();
        efd = 0;
        eur = 0;
        for (int i = 0; i < n; i++) q.push_back(scen[i]);
        while (q.size() > 0) begin
            cur = q.pop_front();
            if (!cur.first) continue;
            for (int k = 0; k < PB; k++) exp_bits.push_back((k % 2) == 0);
            for (int k = 7; k >= 0; k--) exp_bits.push_back(sw[k]);
            crc = 8'h00;
            forever begin
                for (int k = 7; k >= 0; k--) begin
                    exp_bits.push_back(cur.data[k]);
                    crc = crc_step(crc, cur.data[k]);
                end
                if (cur.last) begin
`ifdef BPSK_TX_CRC8_EN
                    for (int k = 7; k >= 0; k--) exp_bits.push_back(crc[k]);
`endif
                    efd++;
                    break;
                end
                if (q.size() == 0) begin
                    eur++;
                    break;
                end
                if (q[0].first) begin
                    efd++;
                    break;
                end
                cur = q.pop_front();
            end
        end
        s_bits   = cap_bits.size();
        s_starts = starts.size();
        s_act    = act_cyc;
        s_fd     = fd_cnt;
        s_ur     = ur_cnt;
        s_ov     = ov_cnt;
        s_viol   = viol;
    endtask

    task automatic push_entry(input fifo_entry_t e);
        src_if.Byte     = e.data;
        src_if.Sync     = e.first;
        src_if.lastByte = e.last;
        src_if.pushByte = 1'b1;
        @(posedge clk);
        #1;
        src_if.pushByte = 1'b0;
        src_if.Sync     = 1'b0;
        src_if.lastByte = 1'b0;
    endtask

    task automatic add_frame(input int n, input logic with_last);
        for (int i = 0; i < n; i++)
            scen.push_back('{first: (i == 0), last: (with_last && (i == n - 1)), data: 8'($urandom)});
    endtask

    task automatic await_check(input string tag, input int exp_ov);
        int budget;
        int nb, nd;
        budget = 6000;
        while (((fd_cnt - s_fd) + (ur_cnt - s_ur)) < (efd + eur) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check_val({tag, "_in_time"}, 32'(budget > 0), 1);
        repeat (4) @(posedge clk);
        #1;
        nb = cap_bits.size() - s_bits;
        check_val({tag, "_nbits"}, nb, exp_bits.size());
        nd = 0;
        for (int i = 0; i < nb && i < exp_bits.size(); i++)
            if (cap_bits[s_bits + i] != exp_bits[i]) nd++;
        check_val({tag, "_bit_diffs"}, nd, 0);
        check_val({tag, "_active_clks"}, act_cyc - s_act, exp_bits.size() * SPB);
        check_val({tag, "_frame_done"}, fd_cnt - s_fd, efd);
        check_val({tag, "_underrun"}, ur_cnt - s_ur, eur);
        check_val({tag, "_overflow"}, ov_cnt - s_ov, exp_ov);
        check_val({tag, "_bit_rules"}, viol - s_viol, 0);
        check_val({tag, "_idle_active"}, tx_active, 0);
    endtask

    initial begin
        int c0, fd0;
        logic [7:0] v;
        reset           = 1'b1;
        src_if.Byte     = 8'h00;
        src_if.pushByte = 1'b0;
        src_if.Sync     = 1'b0;
        src_if.lastByte = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_bit_out", bit_out, 0);
        check_val("rst_strobe", bit_strobe, 0);
        check_val("rst_active", tx_active, 0);
        check_val("rst_done", frame_done, 0);
        check_val("rst_overflow", overflow, 0);
        check_val("rst_underrun", underrun, 0);
        check_val("rst_stop", src_if.stop, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Two-byte frame; first strobe two clocks after the Sync push.
        scen.delete();
        scen.push_back('{first: 1'b1, last: 1'b0, data: 8'h55});
        scen.push_back('{first: 1'b0, last: 1'b1, data: 8'hA0});
        build_expect(2);
        c0 = cyc;
        foreach (scen[i]) push_entry(scen[i]);
        await_check("two_byte", 0);
        check_val("first_bit_latency", (starts.size() > s_starts) ? starts[s_starts] - c0 : -1, 2);

        // Single-byte frame.
        scen.delete();
        scen.push_back('{first: 1'b1, last: 1'b1, data: 8'hFF});
        build_expect(1);
        push_entry(scen[0]);
        await_check("single", 0);
        check_val("single_bit_after", bit_out, 0);

        // 17 back-to-back pushes into a 16-deep FIFO: the last one is dropped.
        scen.delete();
        add_frame(16, 1'b1);
        scen.push_back('{first: 1'b0, last: 1'b0, data: 8'($urandom)});
        build_expect(16);
        for (int i = 0; i < 17; i++) begin
            push_entry(scen[i]);
            if (i == 14) check_val("stop_at_15", src_if.stop, 0);
            if (i == 15) check_val("stop_at_16", src_if.stop, 1);
        end
        await_check("overflow", 1);

        // Frame missing its last byte.
        scen.delete();
        add_frame(2, 1'b0);
        build_expect(2);
        foreach (scen[i]) push_entry(scen[i]);
        await_check("underrun", 0);

        // Orphan byte ahead of a valid frame.
        scen.delete();
        scen.push_back('{first: 1'b0, last: 1'b0, data: 8'h12});
        add_frame(2, 1'b1);
        build_expect(3);
        foreach (scen[i]) push_entry(scen[i]);
        await_check("orphan", 0);

        // Reset in the middle of the payload.
        scen.delete();
        add_frame(3, 1'b1);
        foreach (scen[i]) push_entry(scen[i]);
        repeat ((PB + 8 + 4) * SPB) @(posedge clk);
        #1;
        check_val("pre_reset_active", tx_active, 1);
        fd0 = fd_cnt;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("mid_rst_bit_out", bit_out, 0);
        check_val("mid_rst_strobe", bit_strobe, 0);
        check_val("mid_rst_active", tx_active, 0);
        check_val("mid_rst_done", frame_done, 0);
        check_val("mid_rst_stop", src_if.stop, 0);
        reset = 1'b0;
        repeat (600) @(posedge clk);
        #1;
        check_val("mid_rst_no_done", fd_cnt - fd0, 0);
        check_val("mid_rst_stays_idle", tx_active, 0);

`ifdef BPSK_TX_CRC8_EN
        scen.delete();
        scen.push_back('{first: 1'b1, last: 1'b1, data: 8'h01});
        build_expect(1);
        push_entry(scen[0]);
        await_check("crc", 0);
        v = 8'h00;
        if (cap_bits.size() >= 8)
            for (int k = 0; k < 8; k++) v = {v[6:0], 1'(cap_bits[cap_bits.size() - 8 + k])};
        check_val("crc_byte", v, 8'h07);
`endif

        // Random traffic: orphans, normal, underrun and truncated frames.
        for (int r = 0; r < 20; r++) begin
            int mode;
            scen.delete();
            for (int i = 0; i < $urandom_range(0, 2); i++)
                scen.push_back('{first: 1'b0, last: 1'($urandom_range(0, 1)), data: 8'($urandom)});
            mode = $urandom_range(0, 3);
            if (mode == 2) begin
                add_frame($urandom_range(1, 4), 1'b0);
            end else if (mode == 3) begin
                add_frame($urandom_range(1, 4), 1'b0);
                add_frame($urandom_range(1, 4), 1'b1);
            end else begin
                add_frame($urandom_range(1, 4), 1'b1);
            end
            build_expect(scen.size());
            foreach (scen[i]) push_entry(scen[i]);
            await_check($sformatf("rnd%0d", r), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
